// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared definitions for the sequenced channel multiplexer.
//   DEF_WIDTH / DEF_CHANNELS : default data width and channel count
//   MODE_DIRECT / MODE_SCAN  : encodings of the mode input
//   state_t                  : FSM state (DIRECT, SCAN, STALL)
package mux_seq_pkg;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 16;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SCAN   = 2'd1,
    STALL  = 2'd2   // scan mode with no channel enabled
  } state_t;
endpackage

// File: rtl/mux_seq_rr_next.sv
// rr_next: combinational round-robin search.
//   ptr   : current channel index
//   ch_en : per-channel enable mask
//   nxt   : next enabled index strictly above ptr, circularly
//           (ptr itself if it is the only one enabled, ptr if none)
//   wrap  : the found index is <= ptr (search crossed the top)
module rr_next #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    ptr,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap
);
  always_comb begin
    logic found;
    int   idx;
    nxt   = ptr;
    wrap  = 1'b0;
    found = 1'b0;
    idx   = 0;
    // Offsets 1..CHANNELS so ptr itself is considered last.
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!found && ch_en[idx]) begin
        found = 1'b1;
        nxt   = SEL_W'(idx);
        wrap  = (idx <= int'(ptr));
      end
    end
  end
endmodule

// File: rtl/mux_seq.sv
// mux_seq: registered N:1 multiplexer with direct-select and round-robin
// scan modes and a valid/ready output.
//   clk, rst          : clock, synchronous active-high reset
//   mode              : 0 direct select, 1 round-robin scan
//   sel, sel_load     : load sel into the channel pointer
//   ch_en             : per-channel scan enable
//   din               : flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   out_ready         : consumer accepts dout
//   out_valid, dout,
//   dout_ch           : captured sample and its channel index
//   scan_wrap         : pulse when the scan pointer wraps
//   sel_err           : pulse when sel_load carries sel >= CHANNELS
module mux_seq
  import mux_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
  output logic                      scan_wrap,
  output logic                      sel_err
);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  state_t           state, nxt_state;
  logic [SEL_W-1:0] ptr, rr_nxt;
  logic             rr_wrap, elig, cap, adv, sel_ok;
  logic [WIDTH-1:0] ch_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = din[i*WIDTH +: WIDTH];
  end

  rr_next #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr (
    .ptr  (ptr),
    .ch_en(ch_en),
    .nxt  (rr_nxt),
    .wrap (rr_wrap)
  );

  // The capture decision follows this cycle's mode/ch_en so a mode change
  // acts on the very next edge; the state register records that decision.
  always_comb begin
    nxt_state = DIRECT;
    if (mode == MODE_SCAN) nxt_state = (|ch_en) ? SCAN : STALL;
  end

  always_comb begin
    elig = 1'b0;
    case (nxt_state)
      DIRECT:  elig = 1'b1;
      SCAN:    elig = ch_en[ptr];
      default: elig = 1'b0;
    endcase
  end

  assign cap    = (!out_valid || out_ready) && elig;
  // Scan advances after a capture, or hops off a disabled pointer.
  assign adv    = (nxt_state == SCAN) && (cap || !ch_en[ptr]);
  assign sel_ok = {1'b0, sel} < CH_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIRECT;
      ptr       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_ch   <= '0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= nxt_state;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;

      // Capture always uses the pointer as it stood before this edge.
      if (cap) begin
        dout      <= ch_data[ptr];
        dout_ch   <= ptr;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A load wins over any advance; a bad load leaves ptr alone.
      if (sel_load) begin
        if (sel_ok) ptr <= sel;
        else        sel_err <= 1'b1;
      end else if (adv) begin
        ptr       <= rr_nxt;
        scan_wrap <= rr_wrap;
      end
    end
  end

  // Kept for debug visibility only; no output depends on it.
  logic unused_state;
  assign unused_state = ^state;
endmodule

// File: tb/tb_mux_seq.sv
module tb_mux_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-channel instance
  logic        rst, mode, sel_load, out_ready;
  logic [3:0]  sel;
  logic [15:0] ch_en;
  logic [255:0] din;
  logic        out_valid, scan_wrap, sel_err;
  logic [15:0] dout;
  logic [3:0]  dout_ch;

  // 12-channel instance for out-of-range select
  logic        sel_load2;
  logic [3:0]  sel2;
  logic [11:0] ch_en2;
  logic [191:0] din2;
  logic        out_valid2, scan_wrap2, sel_err2;
  logic [15:0] dout2;
  logic [3:0]  dout_ch2;

  int n_chk = 0;
  int n_fail = 0;

  mux_seq #(.WIDTH(16), .CHANNELS(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .sel_load(sel_load),
    .ch_en(ch_en), .din(din), .out_ready(out_ready), .out_valid(out_valid),
    .dout(dout), .dout_ch(dout_ch), .scan_wrap(scan_wrap), .sel_err(sel_err)
  );

  mux_seq #(.WIDTH(16), .CHANNELS(12)) dut12 (
    .clk(clk), .rst(rst), .mode(1'b0), .sel(sel2), .sel_load(sel_load2),
    .ch_en(ch_en2), .din(din2), .out_ready(1'b1), .out_valid(out_valid2),
    .dout(dout2), .dout_ch(dout_ch2), .scan_wrap(scan_wrap2), .sel_err(sel_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; sel_load = 1'b0; ch_en = '0; out_ready = 1'b1;
    sel2 = '0; sel_load2 = 1'b0; ch_en2 = '0;
    for (int i = 0; i < 16; i++) din[i*16 +: 16] = 16'(i);
    for (int i = 0; i < 12; i++) din2[i*16 +: 16] = 16'(i);
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_chk++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    n_chk++; if (dout_ch !== 4'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", dout_ch); end
    n_chk++; if ({scan_wrap, sel_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b exp=00", {scan_wrap, sel_err}); end
    rst = 1'b0;
    tick();
    // first edge after reset already captures channel 0 in direct mode
    n_chk++; if (out_valid !== 1'b1 || dout_ch !== 4'd0) begin n_fail++; $display("FAIL first_capture valid=%b ch=%0d exp 1/0", out_valid, dout_ch); end
  endtask

  task automatic test_direct();
    sel = 4'd4; sel_load = 1'b1; tick();
    // capture at the load edge uses the old pointer
    n_chk++; if (dout_ch !== 4'd0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL direct_old_ptr ch=%0d err=%b exp 0/0", dout_ch, sel_err); end
    sel_load = 1'b0; tick();
    n_chk++; if (dout !== 16'h0004 || dout_ch !== 4'd4) begin n_fail++; $display("FAIL direct_sel4 dout=%h ch=%0d exp 0004/4", dout, dout_ch); end
    tick();
    n_chk++; if (dout_ch !== 4'd4) begin n_fail++; $display("FAIL direct_stays ch=%0d exp 4", dout_ch); end
    sel = 4'd8; sel_load = 1'b1; tick();
    sel_load = 1'b0; tick();
    n_chk++; if (dout !== 16'h0008 || dout_ch !== 4'd8) begin n_fail++; $display("FAIL direct_sel8 dout=%h ch=%0d exp 0008/8", dout, dout_ch); end
  endtask

  task automatic test_backpressure();
    sel = 4'd4; sel_load = 1'b1; tick();
    sel_load = 1'b0; tick();
    n_chk++; if (dout !== 16'h0004) begin n_fail++; $display("FAIL bp_setup dout=%h exp 0004", dout); end
    out_ready = 1'b0;
    din[4*16 +: 16] = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      mode = (i == 1) ? 1'b1 : 1'b0;   // a mode flip must not disturb the held sample
      tick();
      n_chk++; if (out_valid !== 1'b1 || dout !== 16'h0004 || dout_ch !== 4'd4) begin
        n_fail++; $display("FAIL bp_hold%0d valid=%b dout=%h ch=%0d exp 1/0004/4", i, out_valid, dout, dout_ch);
      end
    end
    mode = 1'b0; out_ready = 1'b1; tick();
    n_chk++; if (dout !== 16'hBEEF || dout_ch !== 4'd4) begin n_fail++; $display("FAIL bp_release dout=%h ch=%0d exp BEEF/4", dout, dout_ch); end
    din[4*16 +: 16] = 16'h0004;
  endtask

  task automatic test_scan();
    logic [3:0] exp_ch [6];
    logic       exp_wr [6];
    exp_ch = '{4'd1, 4'd4, 4'd8, 4'd1, 4'd4, 4'd8};
    exp_wr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    sel = 4'd1; sel_load = 1'b1; tick();
    sel_load = 1'b0; mode = 1'b1; ch_en = 16'h0112;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b1 || dout_ch !== exp_ch[i] || dout !== 16'(exp_ch[i]) || scan_wrap !== exp_wr[i]) begin
        n_fail++; $display("FAIL scan_step%0d valid=%b ch=%0d dout=%h wrap=%b exp 1/%0d/%0d/%b",
                           i, out_valid, dout_ch, dout, scan_wrap, exp_ch[i], exp_ch[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_stall();
    ch_en = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL stall%0d valid=%b wrap=%b exp 0/0", i, out_valid, scan_wrap); end
    end
    // ptr held at 1: first edge hops 1->15 without capture or wrap
    ch_en = 16'h8000; tick();
    n_chk++; if (out_valid !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL recover_hop valid=%b wrap=%b exp 0/0", out_valid, scan_wrap); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b1 || dout !== 16'h000F || dout_ch !== 4'd15 || scan_wrap !== 1'b1) begin
        n_fail++; $display("FAIL recover%0d valid=%b dout=%h ch=%0d wrap=%b exp 1/000F/15/1", i, out_valid, dout, dout_ch, scan_wrap);
      end
    end
  endtask

  task automatic test_conflict();
    ch_en = 16'h0112; tick();   // ptr 15 disabled: hop to 1
    tick();                     // capture 1, ptr -> 4
    n_chk++; if (dout_ch !== 4'd1) begin n_fail++; $display("FAIL conflict_setup ch=%0d exp 1", dout_ch); end
    sel = 4'd2; sel_load = 1'b1; ch_en = 16'h0116; tick();
    n_chk++; if (dout_ch !== 4'd4 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL conflict_old ch=%0d wrap=%b exp 4/0", dout_ch, scan_wrap); end
    sel_load = 1'b0; tick();
    n_chk++; if (dout_ch !== 4'd2 || dout !== 16'h0002) begin n_fail++; $display("FAIL conflict_new ch=%0d dout=%h exp 2/0002", dout_ch, dout); end
  endtask

  task automatic test_sel_err();
    sel2 = 4'd5; sel_load2 = 1'b1; tick();
    sel_load2 = 1'b0; tick();
    n_chk++; if (dout_ch2 !== 4'd5 || out_valid2 !== 1'b1) begin n_fail++; $display("FAIL err_setup ch=%0d valid=%b exp 5/1", dout_ch2, out_valid2); end
    sel2 = 4'd12; sel_load2 = 1'b1; tick();
    n_chk++; if (sel_err2 !== 1'b1) begin n_fail++; $display("FAIL err_pulse12 got=%b exp 1", sel_err2); end
    sel2 = 4'd13; tick();
    n_chk++; if (sel_err2 !== 1'b1) begin n_fail++; $display("FAIL err_pulse13 got=%b exp 1", sel_err2); end
    sel_load2 = 1'b0; tick();
    n_chk++; if (sel_err2 !== 1'b0 || dout_ch2 !== 4'd5 || dout2 !== 16'h0005) begin
      n_fail++; $display("FAIL err_ptr_kept err=%b ch=%0d dout=%h exp 0/5/0005", sel_err2, dout_ch2, dout2);
    end
    sel2 = 4'd11; sel_load2 = 1'b1; tick();
    n_chk++; if (sel_err2 !== 1'b0) begin n_fail++; $display("FAIL err_edge11 got=%b exp 0", sel_err2); end
    sel_load2 = 1'b0; tick();
    n_chk++; if (dout_ch2 !== 4'd11 || scan_wrap2 !== 1'b0) begin n_fail++; $display("FAIL err_sel11 ch=%0d wrap=%b exp 11/0", dout_ch2, scan_wrap2); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; tick();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre valid=%b exp 1", out_valid); end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0 || dout !== 16'h0000 || dout_ch !== 4'd0) begin
        n_fail++; $display("FAIL midrst%0d valid=%b dout=%h ch=%0d exp 0/0000/0", i, out_valid, dout, dout_ch);
      end
    end
    rst = 1'b0; mode = 1'b0; out_ready = 1'b1; tick();
    n_chk++; if (out_valid !== 1'b1 || dout_ch !== 4'd0) begin n_fail++; $display("FAIL midrst_after valid=%b ch=%0d exp 1/0", out_valid, dout_ch); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_backpressure();
    test_scan();
    test_stall();
    test_conflict();
    test_sel_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_seq.md
MUX_SEQ -- requirements
Module: mux_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 16, meaning input channel count (2..64).
REQ-003 The block SHALL have derived parameter SEL_W, default clog2(CHANNELS), meaning channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct select, 1 = round-robin scan.
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index for sel_load.
REQ-008 The block SHALL have port sel_load, input, 1 bit: load sel into the channel pointer.
REQ-009 The block SHALL have port ch_en, input, CHANNELS bits: per-channel scan enable.
REQ-010 The block SHALL have port din, input, CHANNELS*WIDTH bits: flattened inputs; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts dout.
REQ-012 The block SHALL have port out_valid, output, 1 bit: dout/dout_ch hold a captured sample.
REQ-013 The block SHALL have port dout, output, WIDTH bits: registered selected data.
REQ-014 The block SHALL have port dout_ch, output, SEL_W bits: index of the channel that produced dout.
REQ-015 The block SHALL have port scan_wrap, output, 1 bit: one-cycle pulse when the scan pointer wraps.
REQ-016 The block SHALL have port sel_err, output, 1 bit: one-cycle pulse when sel_load carries sel >= CHANNELS.

Function
REQ-017 Capture SHALL occur on an edge where (!out_valid || out_ready) and the pointer channel is eligible; dout<=din[ptr], dout_ch<=ptr, out_valid<=1.
REQ-018 Eligibility SHALL be: always in direct mode; ch_en[ptr]=1 in scan mode.
REQ-019 Latency SHALL be one cycle: din sampled at edge N appears on dout after edge N.
REQ-020 While out_valid=1 and out_ready=0, dout, dout_ch and out_valid SHALL hold stable regardless of din, sel or mode.
REQ-021 A transfer with no capture at the same edge SHALL clear out_valid.
REQ-022 In direct mode the pointer SHALL change only via sel_load.
REQ-023 In scan mode each capture SHALL advance ptr to the next enabled index above ptr, circularly; the lowest enabled index follows the highest.
REQ-024 scan_wrap SHALL pulse on the edge where the advance yields an index <= current ptr.
REQ-025 In scan mode with ptr not enabled but ch_en nonzero, ptr SHALL advance without capture, one hop per cycle.
REQ-026 In scan mode with ch_en=0, there SHALL be no capture and ptr SHALL hold.
REQ-027 A sel_load with sel < CHANNELS SHALL override any advance that edge; a capture at that edge SHALL use the old ptr.
REQ-028 A sel_load with sel >= CHANNELS SHALL leave ptr unchanged and SHALL pulse sel_err.
REQ-029 A mode change SHALL take effect on the next capture decision and SHALL not disturb a held output.
REQ-030 The FSM SHALL have states DIRECT, SCAN and STALL (scan mode, ch_en=0).
REQ-031 FSM transitions SHALL follow mode and ch_en each cycle.

Reset
REQ-032 While rst=1, the block SHALL set ptr=0, out_valid=0, dout=0, dout_ch=0, scan_wrap=0, sel_err=0 and state=DIRECT.
REQ-033 A reset mid-stream SHALL discard any held sample without a transfer.
REQ-034 The first capture after reset SHALL be possible on the first edge after rst falls.

Structure
REQ-035 Shared package mux_seq_pkg SHALL hold the default WIDTH/CHANNELS, mode encodings (MODE_DIRECT=0, MODE_SCAN=1) and FSM state encodings.
REQ-036 One sub-module, rr_next, SHALL compute the next enabled index and wrap flag from ptr and ch_en (combinational, CHANNELS-parametrised).

Verification (WIDTH=16, CHANNELS=16, din[i]=i unless stated)
REQ-037 Reset: assert rst for 2 cycles mid-stream -> out_valid=0, dout=0x0000, dout_ch=0, no transfer seen.
REQ-038 Direct: mode=0, sel_load sel=4, out_ready=1 -> next sample dout=0x0004, dout_ch=4; then sel=8 -> 0x0008.
REQ-039 Backpressure: out_ready=0, din[4] changed to 0xBEEF -> dout holds 0x0004 until out_ready=1, then next capture gives 0xBEEF.
REQ-040 Scan: mode=1, ch_en=0x0112, out_ready=1 -> dout_ch sequence 1,4,8,1,4,8; scan_wrap pulses on each 8->1 advance.
REQ-041 Stall/recover: ch_en=0 -> out_valid drops after last transfer, ptr holds; ch_en=0x8000 -> stream of 0x000F, scan_wrap every capture.
REQ-042 Conflict/error: sel_load sel=2 coincident with scan capture of ch 4 -> dout_ch=4 then 2; sel_load with out-of-range sel on CHANNELS=12 -> sel_err pulse, ptr unchanged.
